// File: rtl/nibble_demux_pkg.sv
// Shared types and constants for the nibble demultiplexing framer.
package nibble_demux_pkg;

    // Frame assembly state: waiting for SOF, or gathering lanes 1..3.
    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_COLLECT = 1'b1
    } state_t;

    // Lane indices within a four-value frame.
    localparam logic [1:0] LANE0 = 2'd0;
    localparam logic [1:0] LANE1 = 2'd1;
    localparam logic [1:0] LANE2 = 2'd2;
    localparam logic [1:0] LANE3 = 2'd3;

endpackage

// File: rtl/nibble_demux_framer_gap_timer.sv
// Idle-gap timer used by the framer's optional timeout feature
// (NIBBLE_DEMUX_TIMEOUT_EN). Counts idle cycles while running,
// clears on activity, and flags expiry on reaching LIMIT.
module gap_timer #(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic reset_n,
    input  logic run,
    input  logic clear,
    output logic expire
);

    localparam int unsigned CNT_W = $clog2(LIMIT + 1);

    logic [CNT_W-1:0] count;

    assign expire = run && (count == CNT_W'(LIMIT));

    // Gap counter: held at zero when not running, cleared by activity, saturates at LIMIT.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (!run || clear) begin
            count <= '0;
        end else if (!expire) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/nibble_demux_framer.sv
// Receive-side 4:1 demultiplexer: assembles four consecutive WIDTH-bit
// stream values into a frame and updates all four outputs together.
// Optional idle timeout inside a frame: define NIBBLE_DEMUX_TIMEOUT_EN.
module nibble_demux_framer
    import nibble_demux_pkg::*;
#(
    parameter int unsigned WIDTH          = 4,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    input  logic             in_sof,
    output logic [WIDTH-1:0] output1,
    output logic [WIDTH-1:0] output2,
    output logic [WIDTH-1:0] output3,
    output logic [WIDTH-1:0] output4,
    output logic [1:0]       slot,
    output logic             frame_done,
    output logic             frame_err
);

    state_t     state, state_next;
    logic [1:0] slot_next;
    logic [1:0] shadow_idx;
    logic       shadow_we;
    logic       commit;
    logic       err_next;
    logic       timeout;

    // Lanes 0..2 are staged; lane 3 goes straight to output4 on commit.
    logic [WIDTH-1:0] shadow [0:2];

`ifdef NIBBLE_DEMUX_TIMEOUT_EN
    gap_timer #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_gap_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .run     (state == ST_COLLECT),
        .clear   (in_valid),
        .expire  (timeout)
    );
`else
    assign timeout = 1'b0;
`endif

    // An early SOF always restarts at lane 0, otherwise write the current slot.
    assign shadow_idx = in_sof ? LANE0 : slot;

    // Next-state and control decode for frame assembly.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        state_next = state;
        slot_next  = slot;
        shadow_we  = 1'b0;
        commit     = 1'b0;
        err_next   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (in_valid && in_sof) begin
                    shadow_we  = 1'b1;
                    slot_next  = LANE1;
                    state_next = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (in_valid) begin
                    if (in_sof) begin
                        // Partial frame dropped; the new SOF value starts a fresh frame.
                        err_next  = 1'b1;
                        shadow_we = 1'b1;
                        slot_next = LANE1;
                    end else if (slot == LANE3) begin
                        commit     = 1'b1;
                        slot_next  = LANE0;
                        state_next = ST_IDLE;
                    end else begin
                        shadow_we = 1'b1;
                        slot_next = slot + 2'd1;
                    end
                end else if (timeout) begin
                    err_next   = 1'b1;
                    slot_next  = LANE0;
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
                slot_next  = LANE0;
            end
        endcase
    end

    // State and slot registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
            slot  <= LANE0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so all registers update together.
            state <= state_next;
            slot  <= slot_next;
        end
    end

    // Shadow lanes, atomic output update and status pulses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: the small shadow store is reset explicitly so outputs can never expose stale data.
            for (int i = 0; i < 3; i++) begin
                shadow[i] <= '0;
            end
            output1    <= '0;
            output2    <= '0;
            output3    <= '0;
            output4    <= '0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (shadow_we && (shadow_idx == 2'(i))) begin
                    shadow[i] <= in_data;
                end
            end
            if (commit) begin
                output1 <= shadow[0];
                output2 <= shadow[1];
                output3 <= shadow[2];
                output4 <= in_data;
            end
            frame_done <= commit;
            frame_err  <= err_next;
        end
    end

endmodule

// File: tb/tb_nibble_demux_framer.sv
// Directed self-checking bench for nibble_demux_framer with a frame
// scoreboard checked whenever frame_done is observed.
module tb_nibble_demux_framer;

    localparam int unsigned WIDTH = 4;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_valid = 1'b0;
    logic             in_sof = 1'b0;
    logic [WIDTH-1:0] output1, output2, output3, output4;
    logic [1:0]       slot;
    logic             frame_done, frame_err;

    int errors = 0;
    int checks = 0;

    // Scoreboard of expected frames, packed {lane0,lane1,lane2,lane3}.
    logic [15:0] exp_q [$];

    int cyc = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int last_done_cyc = 0;
    int prev_done_cyc = 0;

    nibble_demux_framer #(
        .WIDTH          (WIDTH),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_sof     (in_sof),
        .output1    (output1),
        .output2    (output2),
        .output3    (output3),
        .output4    (output4),
        .slot       (slot),
        .frame_done (frame_done),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Monitor sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        cyc++;
        if (reset_n) begin
            if (frame_done && frame_err) begin
                check("done_err_overlap", 32'd1, 32'd0);
            end
            if (frame_err) err_cnt++;
            if (frame_done) begin
                done_cnt++;
                prev_done_cyc = last_done_cyc;
                last_done_cyc = cyc;
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    check("frame_outputs", {16'd0, output1, output2, output3, output4},
                          {16'd0, exp_q.pop_front()});
                end
            end
        end
    end

    task automatic drive(input logic v, input logic s, input logic [WIDTH-1:0] d);
        @(negedge clk);
        in_valid = v;
        in_sof   = s;
        in_data  = d;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, '0);
    endtask

    task automatic send_frame(input logic [15:0] f);
        exp_q.push_back(f);
        drive(1'b1, 1'b1, f[15:12]);
        drive(1'b1, 1'b0, f[11:8]);
        drive(1'b1, 1'b0, f[7:4]);
        drive(1'b1, 1'b0, f[3:0]);
    endtask

    initial begin
        int d0, e0;

        // Reset state.
        repeat (2) @(negedge clk);
        check("reset_outputs", {16'd0, output1, output2, output3, output4}, 32'd0);
        check("reset_slot", {30'd0, slot}, 32'd0);
        check("reset_pulses", {30'd0, frame_done, frame_err}, 32'd0);
        reset_n = 1'b1;
        idle(2);

        // Frame A,3,7,F: outputs update one edge after the 4th value.
        d0 = done_cnt;
        send_frame(16'hA37F);
        drive(1'b0, 1'b0, '0);
        check("t2_done_high", {31'd0, frame_done}, 32'd1);
        check("t2_out", {16'd0, output1, output2, output3, output4}, 32'h0000A37F);
        check("t2_slot", {30'd0, slot}, 32'd0);
        drive(1'b0, 1'b0, '0);
        check("t2_done_low", {31'd0, frame_done}, 32'd0);
        idle(2);
        check("t2_done_count", done_cnt - d0, 32'd1);

        // Reset mid-frame after SOF + 2 values.
        drive(1'b1, 1'b1, 4'h1);
        drive(1'b1, 1'b0, 4'h2);
        drive(1'b1, 1'b0, 4'h3);
        @(negedge clk);
        in_valid = 1'b0;
        in_sof   = 1'b0;
        #1 reset_n = 1'b0;
        #1;
        check("t1_reset_out", {16'd0, output1, output2, output3, output4}, 32'd0);
        check("t1_reset_slot", {30'd0, slot}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        d0 = done_cnt;
        e0 = err_cnt;
        idle(5);
        check("t1_no_pulses", (done_cnt - d0) + (err_cnt - e0), 32'd0);
        check("t1_slot_after", {30'd0, slot}, 32'd0);

        // Back-to-back frames at full rate.
        d0 = done_cnt;
        send_frame(16'h1234);
        send_frame(16'h5678);
        idle(3);
        check("t3_done_count", done_cnt - d0, 32'd2);
        check("t3_done_spacing", last_done_cyc - prev_done_cyc, 32'd4);
        check("t3_final_out", {16'd0, output1, output2, output3, output4}, 32'h00005678);

        // Valid without SOF in IDLE is silently dropped.
        e0 = err_cnt;
        drive(1'b1, 1'b0, 4'h9);
        drive(1'b1, 1'b0, 4'h9);
        send_frame(16'hBC0D);
        idle(2);
        check("t4_no_err", err_cnt - e0, 32'd0);
        check("t4_out", {16'd0, output1, output2, output3, output4}, 32'h0000BC0D);

        // Early SOF discards the partial frame and restarts.
        e0 = err_cnt;
        drive(1'b1, 1'b1, 4'h1);
        drive(1'b1, 1'b0, 4'h2);
        send_frame(16'hCDEF);
        check("t5_held_out", {16'd0, output1, output2, output3, output4}, 32'h0000BC0D);
        idle(3);
        check("t5_err_count", err_cnt - e0, 32'd1);
        check("t5_out", {16'd0, output1, output2, output3, output4}, 32'h0000CDEF);

        // SOF in the 4th position is an early SOF: error, no update.
        e0 = err_cnt;
        d0 = done_cnt;
        drive(1'b1, 1'b1, 4'h4);
        drive(1'b1, 1'b0, 4'h4);
        drive(1'b1, 1'b0, 4'h4);
        drive(1'b1, 1'b1, 4'h6);
        drive(1'b0, 1'b0, '0);
        check("t5b_err_pulse", {31'd0, frame_err}, 32'd1);
        check("t5b_slot", {30'd0, slot}, 32'd1);
        exp_q.push_back(16'h6789);
        drive(1'b1, 1'b0, 4'h7);
        drive(1'b1, 1'b0, 4'h8);
        drive(1'b1, 1'b0, 4'h9);
        idle(2);
        check("t5b_counts", {(err_cnt - e0), (done_cnt - d0)} , {32'd1, 32'd1});
        check("t5b_out", {16'd0, output1, output2, output3, output4}, 32'h00006789);

        // Idle gap inside a frame: SOF,1 then idle.
        e0 = err_cnt;
        drive(1'b1, 1'b1, 4'h5);
        drive(1'b1, 1'b0, 4'h1);
`ifdef NIBBLE_DEMUX_TIMEOUT_EN
        idle(12);
        check("t6_timeout_err", err_cnt - e0, 32'd1);
        check("t6_timeout_slot", {30'd0, slot}, 32'd0);
`else
        idle(9);
        check("t6_no_timeout_err", err_cnt - e0, 32'd0);
        check("t6_slot_held", {30'd0, slot}, 32'd2);
`endif
        check("t6_out_held", {16'd0, output1, output2, output3, output4}, 32'h00006789);

        check("scoreboard_empty", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
